// File: rtl/bus_slave_responder.sv
// bus_slave_responder
//   Slave-side endpoint of the shared bus. It holds a local register memory.
//   Writes are answered with a one-cycle wack pulse. Reads are answered with a
//   valid/ready response that appears read_latency cycles after ren is sampled.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous reset, active-low
//   address_slave  bus address; the low clog2(mem_depth) bits select the word
//   data           write data
//   wen / ren      write / read strobes for this slave
//   resp_ready     master accepts the read response
//   rdata, rvalid  read response
//   wack           write acknowledge pulse
//   busy           a read is in flight; new requests are dropped
//   err            protocol error pulse (collision or request while busy)
module bus_slave_responder #(
  parameter int unsigned address_length = 12,
  parameter int unsigned data_length    = 32,
  parameter int unsigned mem_depth      = 16,
  parameter int unsigned read_latency   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [address_length-1:0] address_slave,
  input  logic [data_length-1:0]    data,
  input  logic                      wen,
  input  logic                      ren,
  input  logic                      resp_ready,
  output logic [data_length-1:0]    rdata,
  output logic                      rvalid,
  output logic                      wack,
  output logic                      busy,
  output logic                      err
);

  localparam int unsigned IdxBits = $clog2(mem_depth);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t                  state_q, state_d;
  logic [IdxBits-1:0]      idx_q, idx_d;
  logic [IdxBits-1:0]      req_idx;
  logic [3:0]              cnt_q, cnt_d;
  logic [data_length-1:0]  rdata_q, rdata_d;
  logic                    rvalid_q, rvalid_d;
  logic                    wack_q, wack_d;
  logic                    err_q, err_d;
  logic [data_length-1:0]  mem_q [mem_depth];
  logic [data_length-1:0]  mem_d [mem_depth];

  // The address bits above the word index are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^address_slave[address_length-1:IdxBits];

  assign req_idx = address_slave[IdxBits-1:0];

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;
    wack_d   = 1'b0;
    err_d    = 1'b0;
    mem_d    = mem_q;

    case (state_q)
      IDLE: begin
        if (wen && ren) begin
          err_d = 1'b1;
        end else if (wen) begin
          mem_d[req_idx] = data;
          wack_d         = 1'b1;
        end else if (ren) begin
          idx_d = req_idx;
          if (read_latency == 1) begin
            rdata_d  = mem_q[req_idx];
            rvalid_d = 1'b1;
            state_d  = RESP;
          end else begin
            cnt_d   = 4'(read_latency - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        err_d = wen | ren;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          rdata_d  = mem_q[idx_q];
          rvalid_d = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        err_d = wen | ren;
        if (resp_ready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        rvalid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      wack_q   <= 1'b0;
      err_q    <= 1'b0;
      for (int unsigned i = 0; i < mem_depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      wack_q   <= wack_d;
      err_q    <= err_d;
      for (int unsigned i = 0; i < mem_depth; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign wack   = wack_q;
  assign err    = err_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_bus_slave_responder.sv
// Testbench for bus_slave_responder. Two instances are exercised in parallel,
// one with read_latency=2 and one with read_latency=1. Drivers push expected
// responses (wack cycle, err cycle, read data with issue/first-valid cycles)
// into per-instance queues; a negedge monitor compares every output against
// those queues each cycle.
module tb_bus_slave_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          issue;
    int          rise;
  } rd_t;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned RL = (g == 0) ? 2 : 1;

    logic        rst, wen, ren, resp_ready;
    logic [11:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    logic        rvalid, wack, busy, err;
    bit          done = 1'b0;

    rd_t         rdq[$];
    int          wq[$];
    int          eq[$];
    logic [31:0] mem_m [16];
    logic [31:0] prev_rdata;
    logic        prev_hold = 1'b0;

    bus_slave_responder #(
      .address_length(12),
      .data_length   (32),
      .mem_depth     (16),
      .read_latency  (RL)
    ) dut (
      .clk          (clk),
      .rst          (rst),
      .address_slave(addr),
      .data         (data),
      .wen          (wen),
      .ren          (ren),
      .resp_ready   (resp_ready),
      .rdata        (rdata),
      .rvalid       (rvalid),
      .wack         (wack),
      .busy         (busy),
      .err          (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL dut%0d %s: got %h, expected %h (cycle %0d)", g, name, act, exp, cyc);
      end
    endtask

    // Monitor: derive every expected output from the scoreboard queues.
    always @(negedge clk) begin
      logic exp_w, exp_e, exp_b, exp_v;
      exp_w = (wq.size() > 0) && (wq[0] == cyc);
      exp_e = (eq.size() > 0) && (eq[0] == cyc);
      exp_b = (rdq.size() > 0) && (cyc >= rdq[0].issue);
      exp_v = (rdq.size() > 0) && (cyc >= rdq[0].rise);
      check("wack", 32'(wack), 32'(exp_w));
      check("err", 32'(err), 32'(exp_e));
      check("busy", 32'(busy), 32'(exp_b));
      check("rvalid", 32'(rvalid), 32'(exp_v));
      if (rvalid && exp_v) check("rdata", rdata, rdq[0].data);
      if (rvalid && prev_hold) check("rdata_hold", rdata, prev_rdata);
      prev_hold  = rvalid && !resp_ready;
      prev_rdata = rdata;
      while (wq.size() > 0 && wq[0] <= cyc) void'(wq.pop_front());
      while (eq.size() > 0 && eq[0] <= cyc) void'(eq.pop_front());
      if (exp_v && resp_ready) void'(rdq.pop_front());
    end

    task automatic step();
      @(posedge clk);
      #1;
    endtask

    task automatic do_write(input logic [11:0] a, input logic [31:0] d);
      wen  = 1'b1;
      addr = a;
      data = d;
      wq.push_back(cyc + 1);
      mem_m[a[3:0]] = d;
      step();
      wen = 1'b0;
    endtask

    task automatic do_collide(input logic [11:0] a, input logic [31:0] d);
      wen  = 1'b1;
      ren  = 1'b1;
      addr = a;
      data = d;
      eq.push_back(cyc + 1);
      step();
      wen = 1'b0;
      ren = 1'b0;
    endtask

    // Read with 'hold' cycles of backpressure; inj[0]/inj[1] inject a
    // wen/ren request during the first backpressure cycle.
    task automatic do_read(input logic [11:0] a, input int hold, input logic [1:0] inj,
                           input logic [11:0] ia, input logic [31:0] id);
      rd_t e;
      int  t;
      e.data  = mem_m[a[3:0]];
      e.issue = cyc + 1;
      e.rise  = cyc + int'(RL);
      rdq.push_back(e);
      ren  = 1'b1;
      addr = a;
      step();
      ren = 1'b0;
      t = 0;
      while (!rvalid && t < 50) begin
        step();
        t++;
      end
      if (!rvalid) begin
        n_tests++;
        n_fail++;
        $display("FAIL dut%0d read_timeout: rvalid=0, expected 1 within 50 cycles", g);
        rdq.delete();
        return;
      end
      for (int h = 0; h < hold; h++) begin
        if (h == 0 && inj != 2'b00) begin
          wen  = inj[0];
          ren  = inj[1];
          addr = ia;
          data = id;
          eq.push_back(cyc + 1);
        end
        step();
        wen = 1'b0;
        ren = 1'b0;
      end
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
    endtask

    task automatic do_reset_mid_read(input logic [11:0] a);
      rd_t e;
      e.data  = mem_m[a[3:0]];
      e.issue = cyc + 1;
      e.rise  = cyc + int'(RL);
      rdq.push_back(e);
      ren  = 1'b1;
      addr = a;
      step();
      ren = 1'b0;
      rst = 1'b0;
      step();
      rdq.delete();
      for (int i = 0; i < 16; i++) mem_m[i] = '0;
      step();
      rst = 1'b1;
    endtask

    initial begin
      logic [11:0]  ra;
      logic [31:0]  rd;
      int unsigned  op;
      for (int i = 0; i < 16; i++) mem_m[i] = '0;
      rst        = 1'b0;
      wen        = 1'b1;
      ren        = 1'b0;
      resp_ready = 1'b0;
      addr       = 12'h005;
      data       = 32'hFFFF_FFFF;
      repeat (5) step();
      rst = 1'b1;
      wen = 1'b0;
      step();

      do_read(12'h000, 0, 2'b00, '0, '0);
      do_write(12'h100, 32'h1010_1010);
      do_read(12'h100, 0, 2'b00, '0, '0);
      do_write(12'h001, 32'h0101_0101);
      do_read(12'h001, 10, 2'b00, '0, '0);
      do_write(12'h002, 32'h2222_2222);
      do_collide(12'h002, 32'hDEAD_BEEF);
      do_read(12'h002, 0, 2'b00, '0, '0);
      do_write(12'h003, 32'h3333_3333);
      do_read(12'h001, 3, 2'b01, 12'h003, 32'h0BAD_0BAD);
      do_read(12'h003, 1, 2'b00, '0, '0);
      do_write(12'h111, 32'h1111_1111);
      do_read(12'h001, 0, 2'b00, '0, '0);
      do_write(12'h010, 32'hA5A5_0010);
      do_read(12'h000, 2, 2'b10, 12'h000, '0);
      do_reset_mid_read(12'h001);
      do_read(12'h001, 0, 2'b00, '0, '0);
      do_read(12'h00F, 0, 2'b00, '0, '0);

      for (int i = 0; i < 200; i++) begin
        op = $urandom_range(0, 9);
        ra = 12'($urandom);
        rd = $urandom;
        if (op < 4) do_write(ra, rd);
        else if (op < 8) do_read(ra, int'($urandom_range(0, 4)), 2'($urandom_range(0, 3)),
                                 12'($urandom), $urandom);
        else if (op == 8) do_collide(ra, rd);
        else step();
      end
      repeat (3) step();
      check("queues_drained", 32'(rdq.size() + wq.size() + eq.size()), 32'd0);
      done = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(g_dut[0].done && g_dut[1].done) && t < 60000) begin
      @(posedge clk);
      t++;
    end
    if (!(g_dut[0].done && g_dut[1].done)) begin
      n_tests++;
      n_fail++;
      $display("FAIL global_timeout: drivers not done after %0d cycles", t);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_slave_responder.md
Name: bus_slave_responder

Overview:
- Slave-side endpoint of the two-master shared bus.
- Consumes the slave address, write data and per-slave wen/ren strobes produced by the bus decoder.
- Holds a small local register memory and returns writes as a one-cycle acknowledge and reads as a valid/ready-handshaked response after a fixed latency.
- One instance per slave port (s1, s2, s3).

Parameters:
- address_length, 12, width of address_slave.
- data_length, 32, width of write and read data.
- mem_depth, 16, number of data_length-bit words; power of two, ≥2; idx_bits = clog2(mem_depth).
- read_latency, 2, cycles from the edge sampling ren to the first cycle rvalid is high; legal range 1..15.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-low.
- address_slave  in  address_length  bus address; word index = address_slave[idx_bits-1:0], upper bits ignored.
- data  in  data_length  write data.
- wen  in  1  write strobe for this slave.
- ren  in  1  read strobe for this slave.
- resp_ready  in  1  master accepts read response.
- rdata  out  data_length  read response data.
- rvalid  out  1  read response valid.
- wack  out  1  write acknowledge pulse.
- busy  out  1  read in progress; new requests are not accepted.
- err  out  1  protocol error pulse.

Behaviour:
- Interface: one clock; reset is synchronous and active-low. rst sampled low at a clk edge puts the block in reset; no asynchronous path.
- Reset values: state=IDLE, rdata=0, rvalid=0, wack=0, busy=0, err=0, latency counter=0, all mem words=0. Reset mid-read aborts the read with no response; rvalid is low the cycle after the reset edge.
- FSM states: IDLE, WAIT, RESP. busy = (state != IDLE), combinational from the state register.
- IDLE, wen=1 and ren=0: mem[idx] <= data at that edge; wack=1 for exactly the following cycle; stay in IDLE. Back-to-back writes give back-to-back wack pulses.
- IDLE, ren=1 and wen=0: latch idx.
  - read_latency=1: go to RESP; rdata <= mem[idx] at the same edge.
  - read_latency>1: go to WAIT with counter = read_latency-1.
- WAIT: counter decrements each cycle. On the edge where counter==1: rdata <= mem[latched idx], rvalid <= 1, go to RESP. rvalid is therefore first high read_latency cycles after the sampling edge.
- RESP: rvalid=1; rdata held stable.
  - On an edge with resp_ready=1: rvalid <= 0 and go to IDLE. A new request can be accepted on the following edge.
  - resp_ready=0: hold indefinitely, no timeout.
- wen=1 and ren=1 in IDLE: no memory access, no state change; err=1 for the next cycle.
- wen or ren asserted in WAIT or RESP: request dropped, memory untouched; err=1 for the next cycle. The in-flight read is unaffected.
- Write-then-read to the same index on consecutive edges returns the new data.
- The index wraps naturally. Address 'h010 and 'h000 alias to word 0 when mem_depth=16.
- wack and err are single-cycle registered pulses. They are never held.

Test Plan:
- Reset hold: rst=0 for 5 cycles with wen=1, data='hFFFFFFFF -> wack=0, err=0, busy=0, rvalid=0. Then a read of 'h000 returns rdata='h00000000.
- Write then read, read_latency=2: write 'h100/'h10101010 -> wack high exactly one cycle after the edge. Read 'h100 -> busy next cycle; rvalid rises 2 cycles after the ren edge with rdata='h10101010. resp_ready=1 -> rvalid low next cycle, busy=0.
- Backpressure: read 'h001 after writing 'h01010101, resp_ready=0 for 10 cycles -> rvalid and rdata stable for all 10 cycles. resp_ready=1 -> single acceptance, back to IDLE.
- Collisions: wen=ren=1 in IDLE at 'h002 -> err one cycle, mem[2] unchanged. wen at 'h003 while in RESP -> err one cycle, mem[3] unchanged, pending response data unchanged.
- Aliasing and latency: mem_depth=16. Write 'h111/'h11111111, read 'h001 -> 'h11111111. Repeat with read_latency=1 -> rvalid on the cycle immediately after the ren edge.
- Reset mid-read: rst=0 during WAIT -> rvalid never asserts, busy=0 after the reset edge. A subsequent read of any index returns 0.
